mem_port_arbiter: RTL and testbench

- Shares the SoC's single-ported instruction/data memory between two requesters: the instruction fetch unit (IF) and the load/store path (LSU), which is driven by the control unit's load and store (sw) decode outputs.
- Round-robin grant, one outstanding transaction at a time.
- Loads wait for the memory's read-valid. A watchdog turns a hung read into an error response.
- Sits between the rv32i core and the memory/UART MMIO fabric.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/arb_rr2.sv | 34 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Read data returned alongside a timeout error.
  localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, LSU) and memory-side signals of the arbiter.
// slave: arbiter view; master: requesters plus memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              lsu_req;
  logic              lsu_we;
  logic [BE_W-1:0]   lsu_be;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_err;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way winner select: round-robin by default, fixed LSU priority
// when ARB_LSU_PRIORITY_EN is defined.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_if,
  input  logic   req_lsu,
  input  logic   take,
  output owner_e winner_c
);

`ifdef ARB_LSU_PRIORITY_EN
  logic unused;
  assign unused   = ^{clk, reset, take, req_if};
  assign winner_c = req_lsu ? OWN_LSU : OWN_IF;
`else
  logic rr_ptr;

  always_comb begin
    winner_c = OWN_IF;
    if (req_if && req_lsu) winner_c = rr_ptr ? OWN_LSU : OWN_IF;
    else if (req_lsu)      winner_c = OWN_LSU;
  end

  // Pointer moves to the loser on every grant, even an uncontested one.
  always_ff @(posedge clk) begin
    if (reset)     rr_ptr <= 1'b0;
    else if (take) rr_ptr <= (winner_c == OWN_IF);
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF and LSU, one transaction at a time,
// with a read watchdog. Optional macro: ARB_LSU_PRIORITY_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reset_q;
  logic              blocked_c;
  logic              take_c;
  logic              done_c;
  owner_e            winner_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] rdata_c;

  // Outputs stay quiet during reset and the first cycle after it.
  assign blocked_c = reset | reset_q;

  arb_rr2 u_sel (
    .clk      (clk),
    .reset    (reset),
    .req_if   (bus.if_req),
    .req_lsu  (bus.lsu_req),
    .take     (take_c),
    .winner_c (winner_c)
  );

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    take_c         = 1'b0;
    done_c         = 1'b0;
    addr_c         = '0;
    rdata_c        = '0;
    bus.if_gnt     = 1'b0;
    bus.if_rvalid  = 1'b0;
    bus.if_rdata   = '0;
    bus.if_err     = 1'b0;
    bus.lsu_gnt    = 1'b0;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_rdata  = '0;
    bus.lsu_err    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (!blocked_c && (bus.if_req || bus.lsu_req)) begin
          take_c      = 1'b1;
          bus.mem_req = 1'b1;
          if (winner_c == OWN_IF) begin
            bus.if_gnt  = 1'b1;
            bus.mem_be  = '1;
            addr_c      = bus.if_addr;
          end else begin
            bus.lsu_gnt   = 1'b1;
            bus.mem_we    = bus.lsu_we;
            bus.mem_be    = bus.lsu_be;
            bus.mem_wdata = bus.lsu_wdata;
            addr_c        = bus.lsu_addr;
          end
          bus.mem_addr = addr_c;
          // Stores retire on grant; reads wait for data.
          if (winner_c == OWN_IF || !bus.lsu_we) begin
            state_d = ST_WAIT;
            owner_d = winner_c;
            cnt_d   = '0;
          end
        end
      end

      ST_WAIT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        done_c = bus.mem_rvalid || (cnt_q == CNT_W'(TIMEOUT - 1));
        if (!blocked_c && done_c) begin
          state_d = ST_IDLE;
          rdata_c = bus.mem_rvalid ? bus.mem_rdata : DATA_W'(ERR_RDATA);
          if (owner_q == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_err    = !bus.mem_rvalid;
            bus.if_rdata  = rdata_c;
          end else begin
            bus.lsu_rvalid = 1'b1;
            bus.lsu_err    = !bus.mem_rvalid;
            bus.lsu_rdata  = rdata_c;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] A_IF    = 32'h0000_0600;
  localparam logic [31:0] A_LSU   = 32'h0000_0700;

`ifdef ARB_LSU_PRIORITY_EN
  localparam bit LSU_PRIO = 1'b1;
`else
  localparam bit LSU_PRIO = 1'b0;
`endif

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        lsu_req;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Requests must be held until granted.
  assert property (@(posedge clk) disable iff (reset) (bus.if_req && !bus.if_gnt) |=> bus.if_req)
    else $error("if_req dropped before grant");
  assert property (@(posedge clk) disable iff (reset) (bus.lsu_req && !bus.lsu_gnt) |=> bus.lsu_req)
    else $error("lsu_req dropped before grant");

  function automatic in_t in_none();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t in_if(input logic [31:0] a);
    in_t v;
    v = '0; v.if_req = 1'b1; v.if_addr = a;
    return v;
  endfunction

  function automatic in_t in_lsu(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    in_t v;
    v = '0; v.lsu_req = 1'b1; v.lsu_we = we; v.lsu_be = be; v.lsu_addr = a; v.lsu_wdata = d;
    return v;
  endfunction

  function automatic in_t in_rv(input logic [31:0] d);
    in_t v;
    v = '0; v.mem_rvalid = 1'b1; v.mem_rdata = d;
    return v;
  endfunction

  function automatic in_t in_merge(input in_t a, input in_t b);
    in_t v;
    v = a | b;
    return v;
  endfunction

  function automatic out_t o_zero();
    out_t e;
    e = '0;
    return e;
  endfunction

  function automatic out_t o_if_gnt(input logic [31:0] a);
    out_t e;
    e = '0; e.if_gnt = 1'b1; e.mem_req = 1'b1; e.mem_be = 4'hF; e.mem_addr = a;
    return e;
  endfunction

  function automatic out_t o_lsu_gnt(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    out_t e;
    e = '0; e.lsu_gnt = 1'b1; e.mem_req = 1'b1; e.mem_we = we; e.mem_be = be; e.mem_addr = a; e.mem_wdata = d;
    return e;
  endfunction

  function automatic out_t o_if_rv(input logic [31:0] d, input logic err);
    out_t e;
    e = '0; e.if_rvalid = 1'b1; e.if_err = err; e.if_rdata = d;
    return e;
  endfunction

  function automatic out_t o_lsu_rv(input logic [31:0] d, input logic err);
    out_t e;
    e = '0; e.lsu_rvalid = 1'b1; e.lsu_err = err; e.lsu_rdata = d;
    return e;
  endfunction

  task automatic drive(input in_t v);
    bus.if_req     = v.if_req;
    bus.if_addr    = v.if_addr;
    bus.lsu_req    = v.lsu_req;
    bus.lsu_we     = v.lsu_we;
    bus.lsu_be     = v.lsu_be;
    bus.lsu_addr   = v.lsu_addr;
    bus.lsu_wdata  = v.lsu_wdata;
    bus.mem_rvalid = v.mem_rvalid;
    bus.mem_rdata  = v.mem_rdata;
  endtask

  function automatic out_t sample();
    out_t o;
    o.if_gnt     = bus.if_gnt;
    o.if_rvalid  = bus.if_rvalid;
    o.if_err     = bus.if_err;
    o.if_rdata   = bus.if_rdata;
    o.lsu_gnt    = bus.lsu_gnt;
    o.lsu_rvalid = bus.lsu_rvalid;
    o.lsu_err    = bus.lsu_err;
    o.lsu_rdata  = bus.lsu_rdata;
    o.mem_req    = bus.mem_req;
    o.mem_we     = bus.mem_we;
    o.mem_be     = bus.mem_be;
    o.mem_addr   = bus.mem_addr;
    o.mem_wdata  = bus.mem_wdata;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1ns later, before the next rising edge.
  task automatic step_r(input string name, input logic rst, input in_t v, input out_t exp);
    @(negedge clk);
    reset = rst;
    drive(v);
    #1;
    check(name, exp);
  endtask

  task automatic step(input string name, input in_t v, input out_t exp);
    step_r(name, 1'b0, v, exp);
  endtask

  task automatic grant_cycle(input string name, input logic w, input logic if_on, input logic lsu_on);
    in_t  v;
    out_t e;
    v = in_none();
    if (if_on)  v = in_merge(v, in_if(A_IF));
    if (lsu_on) v = in_merge(v, in_lsu(1'b0, 4'hF, A_LSU, 32'h0));
    e = (w == 1'b0) ? o_if_gnt(A_IF) : o_lsu_gnt(1'b0, 4'hF, A_LSU, 32'h0);
    step(name, v, e);
  endtask

  task automatic resp_cycle(input string name, input logic w, input logic other_on, input logic [31:0] d);
    in_t  v;
    out_t e;
    v = in_rv(d);
    if (other_on) v = in_merge(v, (w == 1'b0) ? in_lsu(1'b0, 4'hF, A_LSU, 32'h0) : in_if(A_IF));
    e = (w == 1'b0) ? o_if_rv(d, 1'b0) : o_lsu_rv(d, 1'b0);
    step(name, v, e);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;
    in_t  junk;
    logic w;

    // IF-only load, stale rvalid, back-to-back stores, short LSU load.
    t.i = in_if(32'h100);                                  t.o = o_if_gnt(32'h100);                          tbl.push_back(t);
    t.i = in_none();                                       t.o = o_zero();                                   tbl.push_back(t);
    t.i = in_none();                                       t.o = o_zero();                                   tbl.push_back(t);
    t.i = in_rv(32'h1234_5678);                            t.o = o_if_rv(32'h1234_5678, 1'b0);               tbl.push_back(t);
    t.i = in_rv(32'hDEAD_BEEF);                            t.o = o_zero();                                   tbl.push_back(t);
    for (int k = 0; k < 4; k++) begin
      t.i = in_lsu(1'b1, 4'b0011, 32'h200, 32'hA5A5);      t.o = o_lsu_gnt(1'b1, 4'b0011, 32'h200, 32'hA5A5); tbl.push_back(t);
    end
    t.i = in_none();                                       t.o = o_zero();                                   tbl.push_back(t);
    t.i = in_lsu(1'b0, 4'hF, 32'h300, 32'h0);              t.o = o_lsu_gnt(1'b0, 4'hF, 32'h300, 32'h0);      tbl.push_back(t);
    t.i = in_rv(32'hCAFE_F00D);                            t.o = o_lsu_rv(32'hCAFE_F00D, 1'b0);              tbl.push_back(t);
    t.i = in_none();                                       t.o = o_zero();                                   tbl.push_back(t);

    reset = 1'b1;
    drive(in_none());
    repeat (2) @(posedge clk);

    step_r("rst_hold", 1'b1, in_if(32'h100), o_zero());
    step_r("rst_after", 1'b0, in_if(32'h100), o_zero());

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

    // Contended loads, each answered one cycle after grant.
    for (int k = 0; k < 4; k++) begin
      w = LSU_PRIO ? 1'b1 : 1'(k % 2);
      grant_cycle($sformatf("tie_gnt%0d", k), w, 1'b1, 1'b1);
      resp_cycle($sformatf("tie_rsp%0d", k), w, 1'b1, 32'h1000 + 32'(k));
    end
    grant_cycle("tie_tail_gnt", 1'b0, 1'b1, 1'b0);
    resp_cycle("tie_tail_rsp", 1'b0, 1'b0, 32'h2000);

    // LSU load that never gets data.
    junk = in_none();
    junk.mem_rdata = 32'hBAD0_BAD0;
    step("to_gnt", in_lsu(1'b0, 4'hF, 32'h400, 32'h0), o_lsu_gnt(1'b0, 4'hF, 32'h400, 32'h0));
    for (int k = 1; k < int'(TIMEOUT); k++) step($sformatf("to_wait%0d", k), junk, o_zero());
    step("to_fire", junk, o_lsu_rv(32'h0, 1'b1));
    step("to_late", in_rv(32'h5555_5555), o_zero());

    // Data arriving on the timeout cycle wins over the error.
    step("edge_gnt", in_if(32'h500), o_if_gnt(32'h500));
    for (int k = 1; k < int'(TIMEOUT); k++) step($sformatf("edge_wait%0d", k), in_none(), o_zero());
    step("edge_data", in_rv(32'h0BAD_CAFE), o_if_rv(32'h0BAD_CAFE, 1'b0));
    step("edge_idle", in_none(), o_zero());

    // Reset two cycles into a fetch abandons it and clears rr_ptr.
    step("rw_gnt", in_if(32'h800), o_if_gnt(32'h800));
    step("rw_wait", in_none(), o_zero());
    step_r("rw_rst", 1'b1, in_none(), o_zero());
    step_r("rw_after", 1'b0, in_rv(32'h1111_2222), o_zero());
    step("rw_late", in_rv(32'h1111_2222), o_zero());
    w = LSU_PRIO ? 1'b1 : 1'b0;
    grant_cycle("rw_tie_gnt", w, 1'b1, 1'b1);
    resp_cycle("rw_tie_rsp", w, 1'b1, 32'h3000);
    grant_cycle("rw_tie_gnt2", ~w, w, ~w);
    resp_cycle("rw_tie_rsp2", ~w, 1'b0, 32'h3001);
    step("final_idle", in_none(), o_zero());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
